clock_set_controller: RTL and testbench

- Button-driven sequencer that lets the user edit the running time or one of four alarm slots, one field at a time.
- Holds a BCD shadow register while editing. On commit it drives the packed set bus plus set_time or set_alarm/alarm_id into the time_view datapath.
- Keeps the four alarm settings in an internal table, so re-editing an alarm starts from its stored value.

---
 rtl/clock_set_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_clock_set_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// Button-driven editor for the running time and four alarm slots.
//
// The user selects a target (time or alarm 0..3) and then edits hours, minutes
// and, for the time only, seconds. All editing happens in a BCD shadow
// register. A commit copies the shadow into the time or alarm outputs and
// raises a strobe for SET_HOLD cycles. Alarm values are kept in a local table,
// so an alarm edit starts from the value last committed for that slot.
//
// Ports:
//   clk, rst       system clock and synchronous active-high reset
//   btn_mode       enter edit from idle; abort while editing (one-cycle pulse)
//   btn_next       confirm target or field and advance (one-cycle pulse)
//   btn_inc        step the selected target or field (one-cycle pulse)
//   cur_time       live packed 24h time, sampled when a time edit begins
//   stime          last committed time value
//   sam_pm         tied low; hours are always issued in 24h form
//   set_time       time commit strobe, high for SET_HOLD cycles
//   set_alarm      alarm commit strobe, high for SET_HOLD cycles
//   alarm_id       alarm slot being edited or committed
//   stime_alarm    last committed alarm value, seconds always zero
//   editing        high whenever the sequencer is not idle
//   edit_field     one-hot {H,M,S} of the field under edit
//   timeout        one-cycle pulse when an edit is dropped for inactivity
//
// Packed layout: [3:0]s0 [6:4]s1 [10:7]m0 [13:11]m1 [17:14]h0 [19:18]h1.

module clock_set_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned SET_HOLD       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic [19:0] cur_time,
  output logic [19:0] stime,
  output logic        sam_pm,
  output logic        set_time,
  output logic        set_alarm,
  output logic [1:0]  alarm_id,
  output logic [19:0] stime_alarm,
  output logic        editing,
  output logic [2:0]  edit_field,
  output logic        timeout
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(SET_HOLD + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(SET_HOLD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelTarget,
    StEditH,
    StEditM,
    StEditS,
    StCommit
  } state_e;

  state_e           state_q;
  logic [2:0]       target_q;     // 0 = time, 1..4 = alarm 0..3
  logic [19:0]      shadow_q;
  logic [19:0]      alarm_tbl_q [4];
  logic [IdleW-1:0] idle_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [19:0]      stime_q;
  logic [19:0]      stime_alarm_q;
  logic [1:0]       alarm_id_q;
  logic             set_time_q;
  logic             set_alarm_q;
  logic             timeout_q;

  // BCD hour step over 00..23. Any 2x hour at or above 23 wraps to 00.
  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    logic [1:0] tens;
    logic [3:0] ones;
    tens = h[5:4];
    ones = h[3:0];
    if (tens == 2'd2 && ones >= 4'd3) return 6'h00;
    if (ones >= 4'd9) return {tens + 2'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

  // BCD step over 00..59, shared by minutes and seconds.
  function automatic logic [6:0] sexa_inc(input logic [6:0] v);
    logic [2:0] tens;
    logic [3:0] ones;
    tens = v[6:4];
    ones = v[3:0];
    if (ones >= 4'd9) begin
      if (tens >= 3'd5) return 7'h00;
      return {tens + 3'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

  logic       any_btn;
  logic       in_edit;
  logic       idle_expire;
  logic       abort;
  logic [1:0] sel_slot;
  logic [19:0] alarm_val;

  always_comb begin
    any_btn     = btn_mode | btn_next | btn_inc;
    in_edit     = (state_q == StSelTarget) || (state_q == StEditH) ||
                  (state_q == StEditM) || (state_q == StEditS);
    // Expiry only counts when no button arrived this cycle; a press wins.
    idle_expire = in_edit && !any_btn && (idle_cnt_q == IdleLast);
    abort       = btn_mode || idle_expire;
    sel_slot    = 2'(target_q - 3'd1);
    alarm_val   = {shadow_q[19:7], 7'd0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      target_q      <= '0;
      shadow_q      <= '0;
      idle_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      stime_q       <= '0;
      stime_alarm_q <= '0;
      alarm_id_q    <= '0;
      set_time_q    <= 1'b0;
      set_alarm_q   <= 1'b0;
      timeout_q     <= 1'b0;
      for (int i = 0; i < 4; i++) alarm_tbl_q[i] <= '0;
    end else begin
      timeout_q <= idle_expire;

      // Inactivity counter: cleared by any press and on every state entry
      // (all entries into editing states are press-driven).
      if (in_edit && !any_btn && !idle_expire) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end else begin
        idle_cnt_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (btn_mode) begin
            state_q  <= StSelTarget;
            target_q <= '0;
          end
        end

        StSelTarget: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (btn_next) begin
            if (target_q == 3'd0) begin
              shadow_q <= cur_time;
            end else begin
              shadow_q   <= alarm_tbl_q[sel_slot];
              alarm_id_q <= sel_slot;
            end
            state_q <= StEditH;
          end else if (btn_inc) begin
            target_q <= (target_q >= 3'd4) ? 3'd0 : target_q + 3'd1;
          end
        end

        StEditH: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (btn_next) begin
            state_q <= StEditM;
          end else if (btn_inc) begin
            shadow_q[19:14] <= hour_inc(shadow_q[19:14]);
          end
        end

        StEditM: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (btn_next) begin
            if (target_q == 3'd0) begin
              state_q <= StEditS;
            end else begin
              // Alarms have no seconds field: commit straight from minutes.
              state_q                 <= StCommit;
              shadow_q[6:0]           <= '0;
              alarm_tbl_q[alarm_id_q] <= alarm_val;
              stime_alarm_q           <= alarm_val;
              set_alarm_q             <= 1'b1;
              hold_cnt_q              <= '0;
            end
          end else if (btn_inc) begin
            shadow_q[13:7] <= sexa_inc(shadow_q[13:7]);
          end
        end

        StEditS: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (btn_next) begin
            state_q    <= StCommit;
            stime_q    <= shadow_q;
            set_time_q <= 1'b1;
            hold_cnt_q <= '0;
          end else if (btn_inc) begin
            shadow_q[6:0] <= sexa_inc(shadow_q[6:0]);
          end
        end

        StCommit: begin
          // Buttons are ignored; the strobe covers exactly SET_HOLD cycles.
          if (hold_cnt_q == HoldLast) begin
            state_q     <= StIdle;
            set_time_q  <= 1'b0;
            set_alarm_q <= 1'b0;
            hold_cnt_q  <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q     <= StIdle;
          set_time_q  <= 1'b0;
          set_alarm_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stime       = stime_q;
    sam_pm      = 1'b0;
    set_time    = set_time_q;
    set_alarm   = set_alarm_q;
    alarm_id    = alarm_id_q;
    stime_alarm = stime_alarm_q;
    timeout     = timeout_q;
    editing     = (state_q != StIdle);
    edit_field  = 3'b000;
    unique case (state_q)
      StEditH: edit_field = 3'b100;
      StEditM: edit_field = 3'b010;
      StEditS: edit_field = 3'b001;
      default: edit_field = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Randomised and directed bench for clock_set_controller. A behavioural model
// tracks the edit session with plain integers (hours, minutes, seconds, slot
// numbers) and converts to the packed BCD layout only when comparing.

module tb_clock_set_controller;

  localparam int unsigned TimeoutCycles = 20;
  localparam int unsigned SetHold       = 4;

  // Model phases of an edit session.
  localparam int PhIdle    = 0;
  localparam int PhChoose  = 1;
  localparam int PhHours   = 2;
  localparam int PhMinutes = 3;
  localparam int PhSeconds = 4;
  localparam int PhStrobe  = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode;
  logic        btn_next;
  logic        btn_inc;
  logic [19:0] cur_time;
  logic [19:0] stime;
  logic        sam_pm;
  logic        set_time;
  logic        set_alarm;
  logic [1:0]  alarm_id;
  logic [19:0] stime_alarm;
  logic        editing;
  logic [2:0]  edit_field;
  logic        timeout;

  always #5 clk = ~clk;

  clock_set_controller #(
    .TIMEOUT_CYCLES(TimeoutCycles),
    .SET_HOLD      (SetHold)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn_mode),
    .btn_next   (btn_next),
    .btn_inc    (btn_inc),
    .cur_time   (cur_time),
    .stime      (stime),
    .sam_pm     (sam_pm),
    .set_time   (set_time),
    .set_alarm  (set_alarm),
    .alarm_id   (alarm_id),
    .stime_alarm(stime_alarm),
    .editing    (editing),
    .edit_field (edit_field),
    .timeout    (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] pack_time(input int h, input int m, input int s);
    logic [19:0] v;
    v[19:18] = 2'(h / 10);
    v[17:14] = 4'(h % 10);
    v[13:11] = 3'(m / 10);
    v[10:7]  = 4'(m % 10);
    v[6:4]   = 3'(s / 10);
    v[3:0]   = 4'(s % 10);
    return v;
  endfunction

  function automatic logic [19:0] rand_time();
    return pack_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
  endfunction

  // ---------------- behavioural model ----------------
  int m_phase, m_target, m_h, m_m, m_s;
  int m_st_h, m_st_m, m_st_s, m_sa_h, m_sa_m, m_aid;
  int m_quiet, m_hold, m_is_alarm;
  int m_tbl_h [4];
  int m_tbl_m [4];
  bit m_timeout;

  task automatic model_step(input bit r, input bit m, input bit n, input bit i,
                            input logic [19:0] ct);
    m_timeout = 1'b0;
    if (r) begin
      m_phase = PhIdle; m_target = 0; m_h = 0; m_m = 0; m_s = 0;
      m_st_h = 0; m_st_m = 0; m_st_s = 0; m_sa_h = 0; m_sa_m = 0; m_aid = 0;
      m_quiet = 0; m_hold = 0; m_is_alarm = 0;
      for (int k = 0; k < 4; k++) begin
        m_tbl_h[k] = 0;
        m_tbl_m[k] = 0;
      end
      return;
    end
    if (m_phase == PhIdle) begin
      if (m) begin
        m_phase = PhChoose; m_target = 0; m_quiet = 0;
      end
    end else if (m_phase == PhStrobe) begin
      m_hold--;
      if (m_hold == 0) m_phase = PhIdle;
    end else if (m) begin
      m_phase = PhIdle;
    end else if (n) begin
      m_quiet = 0;
      case (m_phase)
        PhChoose: begin
          if (m_target == 0) begin
            m_h = ct[19:18] * 10 + ct[17:14];
            m_m = ct[13:11] * 10 + ct[10:7];
            m_s = ct[6:4] * 10 + ct[3:0];
          end else begin
            m_aid = m_target - 1;
            m_h = m_tbl_h[m_aid]; m_m = m_tbl_m[m_aid]; m_s = 0;
          end
          m_phase = PhHours;
        end
        PhHours: m_phase = PhMinutes;
        PhMinutes: begin
          if (m_target == 0) begin
            m_phase = PhSeconds;
          end else begin
            m_tbl_h[m_aid] = m_h; m_tbl_m[m_aid] = m_m;
            m_sa_h = m_h; m_sa_m = m_m;
            m_phase = PhStrobe; m_hold = SetHold; m_is_alarm = 1;
          end
        end
        default: begin
          m_st_h = m_h; m_st_m = m_m; m_st_s = m_s;
          m_phase = PhStrobe; m_hold = SetHold; m_is_alarm = 0;
        end
      endcase
    end else if (i) begin
      m_quiet = 0;
      case (m_phase)
        PhChoose:  m_target = (m_target + 1) % 5;
        PhHours:   m_h = (m_h + 1) % 24;
        PhMinutes: m_m = (m_m + 1) % 60;
        default:   m_s = (m_s + 1) % 60;
      endcase
    end else begin
      m_quiet++;
      if (m_quiet == TimeoutCycles) begin
        m_timeout = 1'b1;
        m_phase = PhIdle;
        m_quiet = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] exp_field;
    exp_field = (m_phase == PhHours) ? 3'b100 : (m_phase == PhMinutes) ? 3'b010 :
                (m_phase == PhSeconds) ? 3'b001 : 3'b000;
    check_eq("editing", 32'(editing), 32'(m_phase != PhIdle));
    check_eq("edit_field", 32'(edit_field), 32'(exp_field));
    check_eq("set_time", 32'(set_time), 32'(m_phase == PhStrobe && m_is_alarm == 0));
    check_eq("set_alarm", 32'(set_alarm), 32'(m_phase == PhStrobe && m_is_alarm == 1));
    check_eq("timeout", 32'(timeout), 32'(m_timeout));
    check_eq("stime", 32'(stime), 32'(pack_time(m_st_h, m_st_m, m_st_s)));
    check_eq("stime_alarm", 32'(stime_alarm), 32'(pack_time(m_sa_h, m_sa_m, 0)));
    check_eq("alarm_id", 32'(alarm_id), 32'(m_aid));
    check_eq("sam_pm", 32'(sam_pm), 32'd0);
  endtask

  // ---------------- stimulus helpers ----------------
  logic [19:0] tb_ct;
  int cnt_set_time, cnt_set_alarm, cnt_timeout, cnt_edit_h;

  task automatic step(input bit r, input bit m, input bit n, input bit i,
                      input logic [19:0] ct);
    rst = r; btn_mode = m; btn_next = n; btn_inc = i; cur_time = ct;
    @(posedge clk);
    #1;
    model_step(r, m, n, i, ct);
    compare_all();
    if (set_time === 1'b1) cnt_set_time++;
    if (set_alarm === 1'b1) cnt_set_alarm++;
    if (timeout === 1'b1) cnt_timeout++;
    if (edit_field === 3'b100) cnt_edit_h++;
  endtask

  task automatic press(input bit m, input bit n, input bit i);
    step(1'b0, m, n, i, tb_ct);
  endtask

  task automatic clear_counts();
    cnt_set_time = 0; cnt_set_alarm = 0; cnt_timeout = 0; cnt_edit_h = 0;
  endtask

  task automatic run_time_edit(input logic [19:0] start, input int nh, input int nm,
                               input int ns);
    tb_ct = start;
    press(1, 0, 0);
    press(0, 1, 0);
    repeat (nh) press(0, 0, 1);
    press(0, 1, 0);
    repeat (nm) press(0, 0, 1);
    press(0, 1, 0);
    repeat (ns) press(0, 0, 1);
    clear_counts();
    press(0, 1, 0);
    repeat (SetHold + 1) press(0, 0, 0);
  endtask

  task automatic run_alarm_edit(input int slot, input int nh, input int nm);
    press(1, 0, 0);
    repeat (slot + 1) press(0, 0, 1);
    press(0, 1, 0);
    repeat (nh) press(0, 0, 1);
    press(0, 1, 0);
    repeat (nm) press(0, 0, 1);
    clear_counts();
    press(0, 1, 0);
    repeat (SetHold + 1) press(0, 0, 0);
  endtask

  initial begin
    tb_ct = pack_time(12, 34, 56);
    step(1, 0, 0, 0, tb_ct);
    step(1, 0, 0, 0, tb_ct);
    check_eq("rst_stime", 32'(stime), 32'd0);
    check_eq("rst_stime_alarm", 32'(stime_alarm), 32'd0);
    check_eq("rst_editing", 32'(editing), 32'd0);
    check_eq("rst_strobes", 32'({set_time, set_alarm, timeout}), 32'd0);

    // Time set 12:34:56 -> 15:35:56.
    run_time_edit(pack_time(12, 34, 56), 3, 1, 0);
    check_eq("time_set_stime", 32'(stime), 32'(pack_time(15, 35, 56)));
    check_eq("time_set_len", 32'(cnt_set_time), 32'(SetHold));
    check_eq("time_set_no_alarm", 32'(cnt_set_alarm), 32'd0);
    check_eq("time_set_editing_after", 32'(editing), 32'd0);

    // Wraps: 22->01, 58->00, 09->10 seconds.
    run_time_edit(pack_time(22, 58, 9), 3, 2, 1);
    check_eq("wrap_stime", 32'(stime), 32'(pack_time(1, 0, 10)));
    run_time_edit(pack_time(9, 9, 19), 1, 1, 1);
    check_eq("carry09_stime", 32'(stime), 32'(pack_time(10, 10, 20)));
    run_time_edit(pack_time(19, 59, 59), 1, 1, 1);
    check_eq("carry19_stime", 32'(stime), 32'(pack_time(20, 0, 0)));

    // Alarm 2 set to 07:05.
    run_alarm_edit(2, 7, 5);
    check_eq("alarm_value", 32'(stime_alarm), 32'(pack_time(7, 5, 0)));
    check_eq("alarm_id", 32'(alarm_id), 32'd2);
    check_eq("alarm_len", 32'(cnt_set_alarm), 32'(SetHold));
    check_eq("alarm_no_time", 32'(cnt_set_time), 32'd0);
    check_eq("alarm_stime_kept", 32'(stime), 32'(pack_time(20, 0, 0)));
    // Re-entry starts from the stored value.
    run_alarm_edit(2, 1, 0);
    check_eq("alarm_reentry", 32'(stime_alarm), 32'(pack_time(8, 5, 0)));

    // Abort by mode+next in the same cycle while editing minutes.
    press(1, 0, 0); press(0, 1, 0); press(0, 1, 0);
    check_eq("abort_in_m", 32'(edit_field), 32'b010);
    clear_counts();
    press(1, 1, 0);
    check_eq("abort_idle", 32'(editing), 32'd0);
    repeat (6) press(0, 0, 0);
    check_eq("abort_no_strobe", 32'(cnt_set_time + cnt_set_alarm), 32'd0);

    // Inactivity timeout in EDIT_H.
    press(1, 0, 0);
    clear_counts();
    press(0, 1, 0);
    repeat (30) press(0, 0, 0);
    check_eq("timeout_pulses", 32'(cnt_timeout), 32'd1);
    check_eq("timeout_h_cycles", 32'(cnt_edit_h), 32'(TimeoutCycles));
    check_eq("timeout_idle", 32'(editing), 32'd0);

    // Reset in the second strobe cycle of a time commit.
    tb_ct = pack_time(1, 2, 3);
    press(1, 0, 0); press(0, 1, 0); press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
    press(0, 0, 0);
    check_eq("rst_commit_pre", 32'(set_time), 32'd1);
    step(1, 0, 0, 0, tb_ct);
    check_eq("rst_commit_strobe", 32'(set_time), 32'd0);
    check_eq("rst_commit_idle", 32'(editing), 32'd0);
    check_eq("rst_commit_stime", 32'(stime), 32'd0);
    run_alarm_edit(2, 0, 0);
    check_eq("rst_table_cleared", 32'(stime_alarm), 32'd0);

    // Randomised run against the model.
    for (int seg = 0; seg < 60; seg++) begin
      int dens;
      dens = (seg % 3 == 0) ? 4 : (seg % 3 == 1) ? 30 : 70;
      for (int c = 0; c < 50; c++) begin
        bit r, m, n, i;
        int pick;
        r = ($urandom_range(0, 399) == 0);
        m = 1'b0; n = 1'b0; i = 1'b0;
        if ($urandom_range(0, 99) < dens) begin
          pick = $urandom_range(0, 9);
          if (pick < 5) i = 1'b1;
          else if (pick < 8) n = 1'b1;
          else if (pick < 9) m = 1'b1;
          else begin
            m = ($urandom_range(0, 1) == 1);
            n = ($urandom_range(0, 1) == 1);
            i = 1'b1;
          end
        end
        step(r, m, n, i, rand_time());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
